// File: rtl/multiport_wr_queue_if.sv
// Purpose : bundles the producer handshakes, the two RAM write ports, the forward probes and the occupancy count of multiport_wr_queue.
// Latency : carries no logic of its own.
// Backpr. : the in*_ready signals are the only back-pressure; the write ports have none.
// Ports   : in0/in1 producer requests (valid/ready/addr/data), wra/wrb RAM write ports,
//           fwda/fwdb forward probes (addr in, hit/data out), count_o occupancy.
// Modports: slave = queue side, master = producer/RAM/probe side.
interface multiport_wr_queue_if #(
    parameter int P_MEM_DEPTH = 16,
    parameter int P_MEM_WIDTH = 32,
    parameter int P_DEPTH     = 8
);
    localparam int LP_INDEX_WIDTH = $clog2(P_MEM_DEPTH);
    localparam int LP_CNT_W       = $clog2(P_DEPTH) + 1;

    logic                      in0_valid_i;
    logic                      in0_ready_o;
    logic [LP_INDEX_WIDTH-1:0] in0_addr_i;
    logic [P_MEM_WIDTH-1:0]    in0_data_i;
    logic                      in1_valid_i;
    logic                      in1_ready_o;
    logic [LP_INDEX_WIDTH-1:0] in1_addr_i;
    logic [P_MEM_WIDTH-1:0]    in1_data_i;

    logic [LP_INDEX_WIDTH-1:0] wra_addr_o;
    logic [P_MEM_WIDTH-1:0]    wra_data_o;
    logic                      wra_valid_o;
    logic [LP_INDEX_WIDTH-1:0] wrb_addr_o;
    logic [P_MEM_WIDTH-1:0]    wrb_data_o;
    logic                      wrb_valid_o;

    logic [LP_INDEX_WIDTH-1:0] fwda_addr_i;
    logic                      fwda_hit_o;
    logic [P_MEM_WIDTH-1:0]    fwda_data_o;
    logic [LP_INDEX_WIDTH-1:0] fwdb_addr_i;
    logic                      fwdb_hit_o;
    logic [P_MEM_WIDTH-1:0]    fwdb_data_o;

    logic [LP_CNT_W-1:0]       count_o;

    modport slave (
        input  in0_valid_i, in0_addr_i, in0_data_i,
        input  in1_valid_i, in1_addr_i, in1_data_i,
        input  fwda_addr_i, fwdb_addr_i,
        output in0_ready_o, in1_ready_o,
        output wra_addr_o, wra_data_o, wra_valid_o,
        output wrb_addr_o, wrb_data_o, wrb_valid_o,
        output fwda_hit_o, fwda_data_o, fwdb_hit_o, fwdb_data_o,
        output count_o
    );

    modport master (
        output in0_valid_i, in0_addr_i, in0_data_i,
        output in1_valid_i, in1_addr_i, in1_data_i,
        output fwda_addr_i, fwdb_addr_i,
        input  in0_ready_o, in1_ready_o,
        input  wra_addr_o, wra_data_o, wra_valid_o,
        input  wrb_addr_o, wrb_data_o, wrb_valid_o,
        input  fwda_hit_o, fwda_data_o, fwdb_hit_o, fwdb_data_o,
        input  count_o
    );
endinterface

// File: rtl/multiport_wr_queue.sv
// Purpose : in-order write-back staging queue, 2 enqueues and 2 RAM writes per cycle, never two writes to one address.
// Latency : accepted on edge N, presented on wra/wrb from cycle N, written to RAM on edge N+1 at the earliest.
// Backpr. : in0 ready while count <= P_DEPTH-1, in1 ready while count <= P_DEPTH-2; the RAM side takes every issued write.
// Ports   : clk_i, rst_i (async, active-high); bus (multiport_wr_queue_if.slave) carrying
//           producer handshakes, wra/wrb write ports, fwda/fwdb probes and count_o.
// Config  : MULTIPORT_WR_QUEUE_FWD_EN enables the forwarding lookup; otherwise fwd outputs are 0.
module multiport_wr_queue #(
    parameter int P_MEM_DEPTH = 16,
    parameter int P_MEM_WIDTH = 32,
    parameter int P_DEPTH     = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    multiport_wr_queue_if.slave   bus
);
    localparam int LP_INDEX_WIDTH = $clog2(P_MEM_DEPTH);
    localparam int LP_PTR_W       = $clog2(P_DEPTH);
    localparam int LP_CNT_W       = LP_PTR_W + 1;

    logic [LP_INDEX_WIDTH-1:0] addr_q [P_DEPTH];
    logic [P_MEM_WIDTH-1:0]    data_q [P_DEPTH];

    logic [LP_PTR_W-1:0] head, tail, head_p1, tail_p1;
    logic [LP_CNT_W-1:0] count, acc_n, iss_n;
    logic                rdy0, rdy1, acc0, acc1, iss_a, iss_b;

    // Ready looks only at the registered count, so it never waits on a same-cycle drain.
    assign rdy0 = !rst_i && (count <= LP_CNT_W'(P_DEPTH - 1));
    assign rdy1 = !rst_i && (count <= LP_CNT_W'(P_DEPTH - 2));
    assign acc0 = bus.in0_valid_i && rdy0;
    assign acc1 = bus.in1_valid_i && rdy1;

    assign head_p1 = head + LP_PTR_W'(1);
    assign tail_p1 = tail + LP_PTR_W'(1);

    // Port B only issues when it would not collide with port A; a colliding
    // pair drains one per cycle, so the younger write lands last.
    assign iss_a = (count != '0);
    assign iss_b = (count >= LP_CNT_W'(2)) && (addr_q[head_p1] != addr_q[head]);

    assign acc_n = LP_CNT_W'(acc0) + LP_CNT_W'(acc1);
    assign iss_n = LP_CNT_W'(iss_a) + LP_CNT_W'(iss_b);

    assign bus.in0_ready_o = rdy0;
    assign bus.in1_ready_o = rdy1;
    assign bus.count_o     = count;

    // Storage is not reset, so data outputs are gated by valid to stay 0 when idle.
    assign bus.wra_valid_o = iss_a;
    assign bus.wra_addr_o  = iss_a ? addr_q[head] : '0;
    assign bus.wra_data_o  = iss_a ? data_q[head] : '0;
    assign bus.wrb_valid_o = iss_b;
    assign bus.wrb_addr_o  = iss_b ? addr_q[head_p1] : '0;
    assign bus.wrb_data_o  = iss_b ? data_q[head_p1] : '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + LP_PTR_W'(iss_n);
            tail  <= tail + LP_PTR_W'(acc_n);
            count <= count + acc_n - iss_n;
        end
    end

    // in0 is always older than in1 when both are accepted together.
    always_ff @(posedge clk_i) begin
        if (acc0) begin
            addr_q[tail] <= bus.in0_addr_i;
            data_q[tail] <= bus.in0_data_i;
        end
        if (acc1) begin
            addr_q[acc0 ? tail_p1 : tail] <= bus.in1_addr_i;
            data_q[acc0 ? tail_p1 : tail] <= bus.in1_data_i;
        end
    end

`ifdef MULTIPORT_WR_QUEUE_FWD_EN
    // Walk oldest to youngest so the last match (closest to tail) wins.
    always_comb begin
        logic [LP_PTR_W-1:0] idx;
        bus.fwda_hit_o  = 1'b0;
        bus.fwda_data_o = '0;
        bus.fwdb_hit_o  = 1'b0;
        bus.fwdb_data_o = '0;
        idx             = head;
        for (int i = 0; i < P_DEPTH; i++) begin
            idx = head + LP_PTR_W'(i);
            if (LP_CNT_W'(i) < count) begin
                if (addr_q[idx] == bus.fwda_addr_i) begin
                    bus.fwda_hit_o  = 1'b1;
                    bus.fwda_data_o = data_q[idx];
                end
                if (addr_q[idx] == bus.fwdb_addr_i) begin
                    bus.fwdb_hit_o  = 1'b1;
                    bus.fwdb_data_o = data_q[idx];
                end
            end
        end
    end
`else
    wire unused_fwd = ^{bus.fwda_addr_i, bus.fwdb_addr_i};
    assign bus.fwda_hit_o  = 1'b0;
    assign bus.fwda_data_o = '0;
    assign bus.fwdb_hit_o  = 1'b0;
    assign bus.fwdb_data_o = '0;
`endif
endmodule

// File: tb/tb_multiport_wr_queue.sv
// Purpose : self-checking bench for multiport_wr_queue against a queue-level reference model.
// Latency : n/a.
// Backpr. : stimulus holds each request until the DUT accepts it.
module tb_multiport_wr_queue;
    localparam int DEP = 8;

    typedef struct packed {
        logic [3:0]  a;
        logic [31:0] d;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multiport_wr_queue_if #(.P_MEM_DEPTH(16), .P_MEM_WIDTH(32), .P_DEPTH(DEP)) bus ();

    multiport_wr_queue #(.P_MEM_DEPTH(16), .P_MEM_WIDTH(32), .P_DEPTH(DEP)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    ent_t        q[$];
    ent_t        exp_log[$];
    ent_t        dut_log[$];
    logic [31:0] dut_ram [16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: an ordered list of pending writes, updated per edge.
    int   m_sz, m_iss;
    logic m_r0, m_r1;
    ent_t m_e;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
        end else begin
            if (bus.wra_valid_o) begin
                dut_ram[bus.wra_addr_o] = bus.wra_data_o;
                m_e = {bus.wra_addr_o, bus.wra_data_o};
                dut_log.push_back(m_e);
            end
            if (bus.wrb_valid_o) begin
                dut_ram[bus.wrb_addr_o] = bus.wrb_data_o;
                m_e = {bus.wrb_addr_o, bus.wrb_data_o};
                dut_log.push_back(m_e);
            end
            m_sz  = q.size();
            m_iss = (m_sz == 0) ? 0 : ((m_sz >= 2 && q[1].a != q[0].a) ? 2 : 1);
            m_r0  = (m_sz <= DEP - 1);
            m_r1  = (m_sz <= DEP - 2);
            repeat (m_iss) void'(q.pop_front());
            if (bus.in0_valid_i && m_r0) begin
                m_e = {bus.in0_addr_i, bus.in0_data_i};
                q.push_back(m_e);
                exp_log.push_back(m_e);
            end
            if (bus.in1_valid_i && m_r1) begin
                m_e = {bus.in1_addr_i, bus.in1_data_i};
                q.push_back(m_e);
                exp_log.push_back(m_e);
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    int          c_sz;
    logic        c_va, c_vb, c_ha, c_hb;
    logic [3:0]  c_aa, c_ab;
    logic [31:0] c_da, c_db, c_fa, c_fb;
    always @(negedge clk) begin
        c_sz = q.size();
        c_va = (c_sz >= 1);
        c_vb = (c_sz >= 2) && (q[1].a != q[0].a);
        c_aa = c_va ? q[0].a : 4'd0;
        c_da = c_va ? q[0].d : 32'd0;
        c_ab = c_vb ? q[1].a : 4'd0;
        c_db = c_vb ? q[1].d : 32'd0;
        c_ha = 1'b0; c_fa = 32'd0;
        c_hb = 1'b0; c_fb = 32'd0;
`ifdef MULTIPORT_WR_QUEUE_FWD_EN
        for (int i = 0; i < c_sz; i++) begin
            if (q[i].a == bus.fwda_addr_i) begin c_ha = 1'b1; c_fa = q[i].d; end
            if (q[i].a == bus.fwdb_addr_i) begin c_hb = 1'b1; c_fb = q[i].d; end
        end
`endif
        chk("cyc_in0_ready", bus.in0_ready_o, !rst && (c_sz <= DEP - 1));
        chk("cyc_in1_ready", bus.in1_ready_o, !rst && (c_sz <= DEP - 2));
        chk("cyc_count",     bus.count_o, c_sz);
        chk("cyc_wra_valid", bus.wra_valid_o, c_va);
        chk("cyc_wra_addr",  bus.wra_addr_o, c_aa);
        chk("cyc_wra_data",  bus.wra_data_o, c_da);
        chk("cyc_wrb_valid", bus.wrb_valid_o, c_vb);
        chk("cyc_wrb_addr",  bus.wrb_addr_o, c_ab);
        chk("cyc_wrb_data",  bus.wrb_data_o, c_db);
        chk("cyc_fwda_hit",  bus.fwda_hit_o, c_ha);
        chk("cyc_fwda_data", bus.fwda_data_o, c_fa);
        chk("cyc_fwdb_hit",  bus.fwdb_hit_o, c_hb);
        chk("cyc_fwdb_data", bus.fwdb_data_o, c_fb);
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v0, input logic [3:0] a0, input logic [31:0] d0,
                         input logic v1, input logic [3:0] a1, input logic [31:0] d1);
        bus.in0_valid_i = v0; bus.in0_addr_i = a0; bus.in0_data_i = d0;
        bus.in1_valid_i = v1; bus.in1_addr_i = a1; bus.in1_data_i = d1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    logic [31:0] d0, d1;
    logic        r0, r1;
    int          log_sz;
    ent_t        first_exp;

    initial begin
        drive(0, 0, 0, 0, 0, 0);
        bus.fwda_addr_i = 4'd0;
        bus.fwdb_addr_i = 4'd0;

        // Reset state
        cyc(2);
        chk("rst_in0_ready", bus.in0_ready_o, 0);
        chk("rst_in1_ready", bus.in1_ready_o, 0);
        chk("rst_count", bus.count_o, 0);
        chk("rst_wra_valid", bus.wra_valid_o, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_in0_ready", bus.in0_ready_o, 1);
        chk("post_rst_in1_ready", bus.in1_ready_o, 1);

        // Basic transfer
        drive(1, 4'd3, 32'hA5A5A5A5, 0, 0, 0);
        cyc(1);
        drive(0, 0, 0, 0, 0, 0);
        chk("basic_wra_valid", bus.wra_valid_o, 1);
        chk("basic_wra_addr", bus.wra_addr_o, 3);
        chk("basic_wra_data", bus.wra_data_o, 32'hA5A5A5A5);
        chk("basic_wrb_valid", bus.wrb_valid_o, 0);
        cyc(1);
        chk("basic_count", bus.count_o, 0);

        // Dual enqueue, dual issue
        drive(1, 4'd1, 32'h11, 1, 4'd2, 32'h22);
        cyc(1);
        drive(0, 0, 0, 0, 0, 0);
        chk("dual_wra_valid", bus.wra_valid_o, 1);
        chk("dual_wra", {bus.wra_addr_o, bus.wra_data_o}, {4'd1, 32'h11});
        chk("dual_wrb_valid", bus.wrb_valid_o, 1);
        chk("dual_wrb", {bus.wrb_addr_o, bus.wrb_data_o}, {4'd2, 32'h22});
        cyc(1);
        chk("dual_count", bus.count_o, 0);

        // Same-address pair
        drive(1, 4'd5, 32'h50, 1, 4'd5, 32'h51);
        cyc(1);
        drive(0, 0, 0, 0, 0, 0);
        chk("same_c1_wra", {bus.wra_valid_o, bus.wra_addr_o, bus.wra_data_o}, {1'b1, 4'd5, 32'h50});
        chk("same_c1_wrb_valid", bus.wrb_valid_o, 0);
        cyc(1);
        chk("same_c2_wra", {bus.wra_valid_o, bus.wra_addr_o, bus.wra_data_o}, {1'b1, 4'd5, 32'h51});
        chk("same_c2_count", bus.count_o, 1);
        cyc(1);
        chk("same_count", bus.count_o, 0);
        chk("same_ram5", dut_ram[5], 32'h51);

        // Forwarding probe: youngest of two same-address entries
        bus.fwda_addr_i = 4'd4;
        bus.fwdb_addr_i = 4'd9;
        drive(1, 4'd4, 32'h40, 1, 4'd4, 32'h44);
        cyc(1);
        drive(0, 0, 0, 0, 0, 0);
`ifdef MULTIPORT_WR_QUEUE_FWD_EN
        chk("fwda_hit", bus.fwda_hit_o, 1);
        chk("fwda_data", bus.fwda_data_o, 32'h44);
`else
        chk("fwda_hit_off", bus.fwda_hit_o, 0);
        chk("fwda_data_off", bus.fwda_data_o, 0);
`endif
        chk("fwdb_hit", bus.fwdb_hit_o, 0);
        cyc(3);
        chk("fwd_drain_count", bus.count_o, 0);

        // Fill: every entry on address 7, so only one issues per cycle
        exp_log.delete();
        dut_log.delete();
        d0 = 32'h100;
        d1 = 32'h200;
        for (int k = 0; k < 7; k++) begin
            drive(1, 4'd7, d0, 1, 4'd7, d1);
            r0 = bus.in0_ready_o;
            r1 = bus.in1_ready_o;
            cyc(1);
            if (r0) d0 = d0 + 1;
            if (r1) d1 = d1 + 1;
        end
        chk("fill_count7", bus.count_o, 7);
        chk("fill_in0_ready", bus.in0_ready_o, 1);
        chk("fill_in1_ready", bus.in1_ready_o, 0);
        for (int k = 0; k < 2; k++) begin
            drive(1, 4'd7, d0, 1, 4'd7, d1);
            r0 = bus.in0_ready_o;
            r1 = bus.in1_ready_o;
            cyc(1);
            if (r0) d0 = d0 + 1;
            if (r1) d1 = d1 + 1;
        end
        chk("fill_hold_count", bus.count_o, 7);
        drive(0, 0, 0, 0, 0, 0);
        cyc(7);
        chk("drain_count", bus.count_o, 0);

        // Refill across the pointer wrap with distinct-address pairs
        for (int k = 0; k < 6; k++) begin
            drive(1, 4'(k), 32'h300 + 32'(k), 1, 4'(k + 8), 32'h400 + 32'(k));
            cyc(1);
        end
        drive(0, 0, 0, 0, 0, 0);
        chk("wrap_wrb_valid", bus.wrb_valid_o, 1);
        chk("wrap_count", bus.count_o, 2);
        cyc(2);
        chk("wrap_count_end", bus.count_o, 0);
        chk("log_size_lit", dut_log.size(), 27);
        chk("log_size", dut_log.size(), exp_log.size());
        first_exp = {4'd7, 32'h100};
        if (dut_log.size() > 0) chk("log_first", dut_log[0], first_exp);
        for (int i = 0; i < dut_log.size() && i < exp_log.size(); i++)
            chk("log_order", dut_log[i], exp_log[i]);

        // Mid-operation asynchronous reset with 5 entries queued
        drive(1, 4'd6, 32'h600, 1, 4'd6, 32'h601);
        cyc(4);
        drive(0, 0, 0, 0, 0, 0);
        chk("mid_count5", bus.count_o, 5);
        log_sz = dut_log.size();
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_wra_valid", bus.wra_valid_o, 0);
        chk("mid_rst_count", bus.count_o, 0);
        chk("mid_rst_in0_ready", bus.in0_ready_o, 0);
        #1 rst = 1'b0;
        cyc(3);
        chk("mid_after_wra_valid", bus.wra_valid_o, 0);
        chk("mid_after_count", bus.count_o, 0);
        chk("mid_no_stale", dut_log.size(), log_sz);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
